// File: rtl/ifetch_queue.sv
// ifetch_queue: fall-through fetch buffer sitting between fetch and decode.
// Holds up to DEPTH {instr, pc, pc+4} triples, with stall back-pressure,
// a redirect flush and an occupancy count.
// Ports:
//   i_clk, i_reset                 clock, sync active-high reset
//   i_ValidF, i_InstrF, i_PCF,
//   i_PCPlus4F, o_ReadyF           fetch-side push handshake
//   i_StallD, o_ValidD, o_InstrD,
//   o_PCD, o_PCPlus4D              decode-side head entry and pop control
//   i_FlushE                       discard every queued entry
//   o_CountF                       occupancy, 0..DEPTH
module ifetch_queue #(
  parameter int              XLEN  = 32,
  parameter int              DEPTH = 4,
  parameter logic [XLEN-1:0] NOP   = 32'h0000_0013,
  localparam int             AW    = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_ValidF,
  input  logic [XLEN-1:0] i_InstrF,
  input  logic [XLEN-1:0] i_PCF,
  input  logic [XLEN-1:0] i_PCPlus4F,
  output logic            o_ReadyF,
  input  logic            i_StallD,
  input  logic            i_FlushE,
  output logic            o_ValidD,
  output logic [XLEN-1:0] o_InstrD,
  output logic [XLEN-1:0] o_PCD,
  output logic [XLEN-1:0] o_PCPlus4D,
  output logic [AW:0]     o_CountF
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // One packed word per entry so the three fields always move together.
  logic [3*XLEN-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  logic              w_ready;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;
  logic [3*XLEN-1:0] w_head;

  assign w_ready = (r_count != FULL);
  assign w_valid = (r_count != '0);
  assign w_push  = i_ValidF & w_ready & ~i_FlushE;
  assign w_pop   = w_valid & ~i_StallD & ~i_FlushE;
  assign w_head  = r_mem[r_rd_ptr];

  // Storage holds no reset; validity is tracked by r_count alone.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_InstrF, i_PCF, i_PCPlus4F};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_FlushE) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is driven from state only, so fetch inputs never reach decode
  // outputs combinationally.
  assign o_ReadyF   = w_ready;
  assign o_ValidD   = w_valid;
  assign o_CountF   = r_count;
  assign o_InstrD   = w_valid ? w_head[3*XLEN-1:2*XLEN] : NOP;
  assign o_PCD      = w_valid ? w_head[2*XLEN-1:XLEN]   : '0;
  assign o_PCPlus4D = w_valid ? w_head[XLEN-1:0]        : '0;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed + random bench for ifetch_queue.
// Reference queue model predicts every head/occupancy observation.
module tb_ifetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset;
  logic            ValidF;
  logic [XLEN-1:0] InstrF;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] PCPlus4F;
  logic            ReadyF;
  logic            StallD;
  logic            FlushE;
  logic            ValidD;
  logic [XLEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic [AW:0]     CountF;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] next_pc;
  int          max_cnt;
  bit          accepted;

  always #5 clk = ~clk;

  ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_ValidF(ValidF),
    .i_InstrF(InstrF),
    .i_PCF(PCF),
    .i_PCPlus4F(PCPlus4F),
    .o_ReadyF(ReadyF),
    .i_StallD(StallD),
    .i_FlushE(FlushE),
    .o_ValidD(ValidD),
    .o_InstrD(InstrD),
    .o_PCD(PCD),
    .o_PCPlus4D(PCPlus4D),
    .o_CountF(CountF)
  );

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return {pc[15:0], 16'h0093} ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare all decode-side outputs against the model head.
  task automatic check_outputs();
    int n;
    n = q.size();
    chk("CountF", 32'(CountF), 32'(n));
    chk("ReadyF", 32'(ReadyF), 32'(n != DEPTH));
    chk("ValidD", 32'(ValidD), 32'(n != 0));
    if (n != 0) begin
      chk("InstrD", InstrD, q[0].instr);
      chk("PCD", PCD, q[0].pc);
      chk("PCPlus4D", PCPlus4D, q[0].pc4);
    end else begin
      chk("InstrD_nop", InstrD, NOPI);
      chk("PCD_zero", PCD, 32'h0);
      chk("PCPlus4D_zero", PCPlus4D, 32'h0);
    end
  endtask

  // One clock: check at negedge, drive, update model at posedge.
  task automatic cyc(input logic v, input logic st, input logic fl,
                     input logic rs);
    bit push, pop;
    ent_t e;
    check_outputs();
    reset    = rs;
    ValidF   = v;
    InstrF   = mk_instr(next_pc);
    PCF      = next_pc;
    PCPlus4F = next_pc + 32'd4;
    StallD   = st;
    FlushE   = fl;
    push = v && (q.size() != DEPTH) && !fl && !rs;
    pop  = (q.size() != 0) && !st && !fl && !rs;
    e.instr = InstrF;
    e.pc    = PCF;
    e.pc4   = PCPlus4F;
    @(posedge clk);
    if (rs || fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    accepted = push;
    if (push) next_pc = next_pc + 32'd4;
    if (q.size() > max_cnt) max_cnt = q.size();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; ValidF = 1'b0; InstrF = '0; PCF = '0;
    PCPlus4F = '0; StallD = 1'b0; FlushE = 1'b0;
    next_pc = 32'h0;
    @(negedge clk);
    // 1. reset for two cycles
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
    check_outputs();

    // 2. streaming with no stall: occupancy never exceeds 1
    max_cnt = 0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("stream_peak", 32'(max_cnt), 32'd1);

    // 3. stall and offer 5 entries: 4 accepted, 5th held
    next_pc = 32'h0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("full_count", 32'(CountF), 32'(DEPTH));
    chk("full_ready", 32'(ReadyF), 32'd0);
    chk("fifth_held_pc", next_pc, 32'h10);

    // 4. full queue with push+pop: only the pop happens
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("fullpop_accept", 32'(accepted), 32'd0);
    chk("fullpop_count", 32'(CountF), 32'd3);
    chk("fullpop_ready", 32'(ReadyF), 32'd1);

    // 5. flush with an offered entry at PC 0x40
    next_pc = 32'h40;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 32'(CountF), 32'd0);
    chk("flush_valid", 32'(ValidD), 32'd0);
    chk("flush_pc", PCD, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // reset beats flush and push mid-stream
    next_pc = 32'h80;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_count", 32'(CountF), 32'd0);
    chk("rst_instr", InstrD, NOPI);

    // drain-after-stall order check including the held 5th entry
    next_pc = 32'h200;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // 6. random valid/stall, pointers wrap many times
    next_pc = 32'h1000;
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 31) == 0), 1'b0);
    end
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
